// File: rtl/change_dispenser_if.sv
// Handshake and status bundle between the change dispenser and its environment.
// The coins_total signal exists only when DISPENSE_STATS_EN is defined.
interface change_dispenser_if #(
    parameter int INV_W = 6
);
    logic             change_valid;
    logic [4:0]       change_in;
    logic             coin_ack;
    logic             refill;
    logic             coin_req;
    logic             coin_sel;
    logic             busy;
    logic             done;
    logic             error;
    logic [4:0]       remaining;
    logic [INV_W-1:0] inv10;
    logic [INV_W-1:0] inv5;
`ifdef DISPENSE_STATS_EN
    logic [7:0]       coins_total;
`endif

    modport slave (
`ifdef DISPENSE_STATS_EN
        output coins_total,
`endif
        input  change_valid, change_in, coin_ack, refill,
        output coin_req, coin_sel, busy, done, error, remaining, inv10, inv5
    );

    modport master (
`ifdef DISPENSE_STATS_EN
        input  coins_total,
`endif
        output change_valid, change_in, coin_ack, refill,
        input  coin_req, coin_sel, busy, done, error, remaining, inv10, inv5
    );
endinterface

// File: rtl/change_dispenser.sv
// Pays out a change amount as Rs 10 / Rs 5 coins, largest first, one ejector handshake per coin.
// Define DISPENSE_STATS_EN to add the saturating coins_total counter.
module change_dispenser #(
    parameter int TIMEOUT_CYCLES = 15,
    parameter int INV_W          = 6,
    parameter int INV10_INIT     = 20,
    parameter int INV5_INIT      = 20
) (
    input  logic               clk,
    input  logic               reset,
    change_dispenser_if.slave  dif
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_WAIT_ACK,
        S_DONE,
        S_FAULT
    } state_t;

    localparam int               TMR_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [INV_W-1:0] INV10_RST = INV_W'(INV10_INIT);
    localparam logic [INV_W-1:0] INV5_RST  = INV_W'(INV5_INIT);

    state_t           state_q, state_d;
    logic [TMR_W-1:0] timer_q;
    logic [4:0]       remaining_q;
    logic [INV_W-1:0] inv10_q, inv5_q;
    logic             coin_sel_q;
    logic             error_q;
    logic             amount_ok, can10, can5, timeout;
    logic             coin_req_o, busy_o, done_o;

    assign amount_ok = (dif.change_in % 5'd5) == 5'd0;
    assign can10     = (remaining_q >= 5'd10) && (inv10_q != '0);
    assign can5      = (remaining_q >= 5'd5) && (inv5_q != '0);
    assign timeout   = timer_q == TMR_LAST;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (dif.change_valid) state_d = amount_ok ? S_CHECK : S_FAULT;
            S_CHECK: begin
                if (remaining_q == 5'd0)  state_d = S_DONE;
                else if (can10 || can5)   state_d = S_WAIT_ACK;
                else                      state_d = S_FAULT;
            end
            // An ack arriving on the expiry cycle still counts as delivered.
            S_WAIT_ACK: begin
                if (dif.coin_ack)  state_d = S_CHECK;
                else if (timeout)  state_d = S_FAULT;
            end
            S_DONE:     state_d = S_IDLE;
            S_FAULT:    state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    always_comb begin
        coin_req_o = (state_q == S_WAIT_ACK);
        busy_o     = (state_q != S_IDLE);
        done_o     = (state_q == S_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer_q     <= '0;
            remaining_q <= '0;
            inv10_q     <= INV10_RST;
            inv5_q      <= INV5_RST;
            coin_sel_q  <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (dif.change_valid) begin
                        remaining_q <= dif.change_in;
                        error_q     <= !amount_ok;
                    end else if (dif.refill) begin
                        inv10_q <= INV10_RST;
                        inv5_q  <= INV5_RST;
                    end
                end
                S_CHECK: begin
                    if (remaining_q != 5'd0) begin
                        if (can10)     coin_sel_q <= 1'b1;
                        else if (can5) coin_sel_q <= 1'b0;
                        else           error_q    <= 1'b1;
                    end
                end
                S_WAIT_ACK: begin
                    if (dif.coin_ack) begin
                        timer_q <= '0;
                        if (coin_sel_q) begin
                            remaining_q <= remaining_q - 5'd10;
                            inv10_q     <= inv10_q - 1'b1;
                        end else begin
                            remaining_q <= remaining_q - 5'd5;
                            inv5_q      <= inv5_q - 1'b1;
                        end
                    end else if (timeout) begin
                        timer_q <= '0;
                        error_q <= 1'b1;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef DISPENSE_STATS_EN
    logic [7:0] coins_total_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            coins_total_q <= '0;
        else if (state_q == S_WAIT_ACK && dif.coin_ack && coins_total_q != 8'hFF)
            coins_total_q <= coins_total_q + 8'd1;
    end

    assign dif.coins_total = coins_total_q;
`endif

    assign dif.coin_req  = coin_req_o;
    assign dif.busy      = busy_o;
    assign dif.done      = done_o;
    assign dif.coin_sel  = coin_sel_q;
    assign dif.error     = error_q;
    assign dif.remaining = remaining_q;
    assign dif.inv10     = inv10_q;
    assign dif.inv5      = inv5_q;
endmodule

// File: tb/tb_change_dispenser.sv
// Randomised scoreboard bench for change_dispenser: greedy-payout reference model,
// ejector responder, and a monitor that checks each transaction when busy falls.
module tb_change_dispenser;
    localparam int INV_W    = 6;
    localparam int INV_INIT = 20;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    change_dispenser_if #(.INV_W(INV_W)) dif ();

    change_dispenser #(
        .TIMEOUT_CYCLES(15),
        .INV_W(INV_W),
        .INV10_INIT(INV_INIT),
        .INV5_INIT(INV_INIT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .dif(dif)
    );

    typedef struct {
        bit       err;
        bit       dn;
        int       rem;
        int       i10;
        int       i5;
        int       n;
        bit [7:0] seq;
    } exp_t;

    exp_t exp_q[$];
    bit   got_q[$];
    int   tests = 0;
    int   fails = 0;
    int   m_i10 = INV_INIT;
    int   m_i5 = INV_INIT;
    int   m_total = 0;
    bit   stall = 1'b0;

    task automatic chk(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Greedy payout: as many Rs 10 coins as stock and amount allow, then Rs 5.
    task automatic model(input int amt, output exp_t e);
        int n10, n5, rest;
        e.seq = '0;
        e.n   = 0;
        e.rem = amt;
        e.err = 1'b1;
        e.dn  = 1'b0;
        if ((amt % 5) == 0 && !(stall && amt > 0)) begin
            n10  = (amt / 10 < m_i10) ? amt / 10 : m_i10;
            rest = amt - 10 * n10;
            n5   = (rest / 5 < m_i5) ? rest / 5 : m_i5;
            rest = rest - 5 * n5;
            m_i10 -= n10;
            m_i5  -= n5;
            m_total = (m_total + n10 + n5 > 255) ? 255 : m_total + n10 + n5;
            for (int i = 0; i < n10; i++) e.seq[i] = 1'b1;
            e.n   = n10 + n5;
            e.rem = rest;
            e.err = (rest != 0);
            e.dn  = (rest == 0);
        end
        e.i10 = m_i10;
        e.i5  = m_i5;
    endtask

    // Ejector: acks each request after a random 0..5 cycle delay unless stalled.
    initial begin
        int cnt = 0;
        int dly = 2;
        dif.coin_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (dif.coin_ack) begin
                dif.coin_ack = 1'b0;
                cnt = 0;
                dly = $urandom_range(0, 5);
            end else if (dif.coin_req && !stall && !reset) begin
                if (cnt >= dly) begin
                    dif.coin_ack = 1'b1;
                    got_q.push_back(dif.coin_sel);
                end else begin
                    cnt++;
                end
            end else if (!dif.coin_req) begin
                cnt = 0;
            end
        end
    end

    // Monitor: a transaction ends when busy falls outside reset.
    initial begin
        bit       busy_p = 1'b0;
        bit       dn = 1'b0;
        bit [7:0] s;
        exp_t     e;
        forever begin
            @(negedge clk);
            if (reset) begin
                busy_p = 1'b0;
                dn = 1'b0;
                got_q.delete();
            end else begin
                if (dif.done) dn = 1'b1;
                if (busy_p && !dif.busy) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_end", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        s = '0;
                        for (int i = 0; i < got_q.size() && i < 8; i++) s[i] = got_q[i];
                        chk("coin_count", got_q.size(), e.n);
                        chk("coin_seq", int'(s), int'(e.seq));
                        chk("error", int'(dif.error), int'(e.err));
                        chk("done_pulse", int'(dn), int'(e.dn));
                        chk("remaining", int'(dif.remaining), e.rem);
                        chk("inv10", int'(dif.inv10), e.i10);
                        chk("inv5", int'(dif.inv5), e.i5);
                    end
                    got_q.delete();
                    dn = 1'b0;
                end
                busy_p = dif.busy;
            end
        end
    end

    task automatic wait_idle();
        int k = 0;
        while (dif.busy && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk("idle_bound", int'(dif.busy), 0);
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic start(input int amt, input bit with_refill);
        exp_t e;
        @(negedge clk);
        dif.change_valid = 1'b1;
        dif.change_in    = 5'(amt);
        dif.refill       = with_refill;
        model(amt, e);
        exp_q.push_back(e);
        @(negedge clk);
        dif.change_valid = 1'b0;
        dif.refill       = 1'b0;
    endtask

    task automatic do_refill();
        @(negedge clk);
        dif.refill = 1'b1;
        @(negedge clk);
        dif.refill = 1'b0;
        m_i10 = INV_INIT;
        m_i5  = INV_INIT;
    endtask

    initial begin
        int amt, k, cnt;
        dif.change_valid = 1'b0;
        dif.change_in    = '0;
        dif.refill       = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(dif.busy), 0);
        chk("rst_coin_req", int'(dif.coin_req), 0);
        chk("rst_remaining", int'(dif.remaining), 0);
        chk("rst_inv10", int'(dif.inv10), INV_INIT);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_done", int'(dif.done), 0);
        chk("rst_error", int'(dif.error), 0);
        chk("rst_inv5", int'(dif.inv5), INV_INIT);

        start(25, 1'b0);
        wait_idle();

        // Zero amount: done two cycles after the strobe, never a coin request.
        start(0, 1'b0);
        chk("zero_busy", int'(dif.busy), 1);
        chk("zero_done_early", int'(dif.done), 0);
        @(negedge clk);
        chk("zero_done", int'(dif.done), 1);
        chk("zero_coin_req", int'(dif.coin_req), 0);
        wait_idle();

        start(7, 1'b0);
        wait_idle();
        start(10, 1'b0);
        wait_idle();

        stall = 1'b1;
        start(10, 1'b0);
        cnt = 0;
        k = 0;
        while (dif.busy && k < 100) begin
            if (dif.coin_req) cnt++;
            @(negedge clk);
            k++;
        end
        chk("timeout_req_cycles", cnt, 15);
        wait_idle();
        stall = 1'b0;

        // Strobe and refill while busy must both be ignored.
        start(20, 1'b0);
        @(negedge clk);
        chk("busy_before_ignore", int'(dif.busy), 1);
        dif.change_valid = 1'b1;
        dif.change_in    = 5'd15;
        dif.refill       = 1'b1;
        @(negedge clk);
        dif.change_valid = 1'b0;
        dif.refill       = 1'b0;
        wait_idle();

        for (int t = 0; t < 60; t++) begin
            if ($urandom_range(0, 9) < 7) amt = 5 * $urandom_range(0, 6);
            else                          amt = $urandom_range(0, 31);
            if ($urandom_range(0, 9) == 0) do_refill();
            start(amt, $urandom_range(0, 9) == 0);
            wait_idle();
        end

`ifdef DISPENSE_STATS_EN
        chk("coins_total", int'(dif.coins_total), m_total);
`endif

        // Reset while a coin is in flight.
        do_refill();
        stall = 1'b1;
        @(negedge clk);
        dif.change_valid = 1'b1;
        dif.change_in    = 5'd10;
        @(negedge clk);
        dif.change_valid = 1'b0;
        k = 0;
        while (!dif.coin_req && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("inflight_req", int'(dif.coin_req), 1);
        #2 reset = 1'b1;
        #1;
        chk("arst_coin_req", int'(dif.coin_req), 0);
        chk("arst_busy", int'(dif.busy), 0);
        chk("arst_remaining", int'(dif.remaining), 0);
        chk("arst_coin_sel", int'(dif.coin_sel), 0);
        chk("arst_inv10", int'(dif.inv10), INV_INIT);
        m_i10 = INV_INIT;
        m_i5  = INV_INIT;
        m_total = 0;
        @(negedge clk);
        reset = 1'b0;
        stall = 1'b0;
        @(negedge clk);
        start(30, 1'b0);
        wait_idle();
`ifdef DISPENSE_STATS_EN
        chk("coins_total_after_reset", int'(dif.coins_total), m_total);
`endif
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
